clock_reset_sequencer: RTL and testbench



---
 rtl/clock_reset_sequencer.sv | 135 +++++++++++++
 tb/tb_clock_reset_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/clock_reset_sequencer.sv
// Sequences a DCM: pulses its reset, waits for a synchronized lock with timeout, then releases system_reset after a settle delay.
// Runs from the raw board clock; lock loss or timeout re-runs the DCM reset up to MaxRetries times before latching failed.
module clock_reset_sequencer #(
    parameter int DcmResetCycles = 4,
    parameter int LockTimeout    = 65535,
    parameter int ReleaseDelay   = 16,
    parameter int MaxRetries     = 7,
    parameter int CounterWidth   = 16,
    parameter int RetryWidth     = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dcm_locked,
    output logic                  dcm_reset,
    output logic                  system_reset,
    output logic                  ready,
    output logic                  failed,
    output logic [RetryWidth-1:0] retry_count
);

    typedef enum logic [2:0] {
        S_DcmReset,
        S_WaitLock,
        S_Settle,
        S_Running,
        S_Failed
    } state_t;

    localparam logic [CounterWidth-1:0] ResetLast   = CounterWidth'(DcmResetCycles - 1);
    localparam logic [CounterWidth-1:0] TimeoutLast = CounterWidth'(LockTimeout - 1);
    localparam logic [CounterWidth-1:0] SettleLast  = CounterWidth'(ReleaseDelay - 1);
    localparam logic [RetryWidth-1:0]   RetryMax    = RetryWidth'(MaxRetries);
    localparam logic [CounterWidth-1:0] CountOne    = CounterWidth'(1);
    localparam logic [RetryWidth-1:0]   RetryOne    = RetryWidth'(1);

    state_t                  state_q, state_d;
    logic [CounterWidth-1:0] counter_q, counter_d;
    logic [RetryWidth-1:0]   retry_q, retry_d;
    logic                    sync1_q, locked_s_q;
    logic                    dcm_reset_q, system_reset_q, ready_q, failed_q;
    logic                    take_retry;

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        retry_d    = retry_q;
        take_retry = 1'b0;
        case (state_q)
            S_DcmReset: begin
                if (counter_q == ResetLast) begin
                    counter_d = '0;
                    state_d   = S_WaitLock;
                end else begin
                    counter_d = counter_q + CountOne;
                end
            end
            S_WaitLock: begin
                // Lock takes priority over a timeout expiring in the same cycle.
                if (locked_s_q) begin
                    counter_d = '0;
                    state_d   = S_Settle;
                end else if (counter_q == TimeoutLast) begin
                    take_retry = 1'b1;
                end else begin
                    counter_d = counter_q + CountOne;
                end
            end
            S_Settle: begin
                if (!locked_s_q) begin
                    counter_d = '0;
                    state_d   = S_WaitLock;
                end else if (counter_q == SettleLast) begin
                    counter_d = '0;
                    state_d   = S_Running;
                end else begin
                    counter_d = counter_q + CountOne;
                end
            end
            S_Running: begin
                if (!locked_s_q) begin
                    take_retry = 1'b1;
                end
            end
            S_Failed: begin
                state_d = S_Failed;
            end
            default: begin
                counter_d = '0;
                state_d   = S_DcmReset;
            end
        endcase

        if (take_retry) begin
            if (retry_q == RetryMax) begin
                state_d = S_Failed;
            end else begin
                retry_d   = (retry_q == '1) ? retry_q : retry_q + RetryOne;
                counter_d = '0;
                state_d   = S_DcmReset;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_DcmReset;
            counter_q      <= '0;
            retry_q        <= '0;
            sync1_q        <= 1'b0;
            locked_s_q     <= 1'b0;
            dcm_reset_q    <= 1'b1;
            system_reset_q <= 1'b1;
            ready_q        <= 1'b0;
            failed_q       <= 1'b0;
        end else begin
            sync1_q        <= dcm_locked;
            locked_s_q     <= sync1_q;
            state_q        <= state_d;
            counter_q      <= counter_d;
            retry_q        <= retry_d;
            // Outputs decode the next state so they change on the same edge as the state.
            dcm_reset_q    <= (state_d == S_DcmReset);
            system_reset_q <= (state_d != S_Running);
            ready_q        <= (state_d == S_Running);
            failed_q       <= (state_d == S_Failed);
        end
    end

    assign dcm_reset    = dcm_reset_q;
    assign system_reset = system_reset_q;
    assign ready        = ready_q;
    assign failed       = failed_q;
    assign retry_count  = retry_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: directed stimulus queues each expected output change with its
// edge number; an independent monitor compares every observed output change against the queue.
module tb_clock_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       dcm_locked;
    logic       dcm_reset;
    logic       system_reset;
    logic       ready;
    logic       failed;
    logic [2:0] retry_count;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    clock_reset_sequencer #(
        .DcmResetCycles(4),
        .LockTimeout   (20),
        .ReleaseDelay  (8),
        .MaxRetries    (2),
        .CounterWidth  (16),
        .RetryWidth    (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dcm_locked  (dcm_locked),
        .dcm_reset   (dcm_reset),
        .system_reset(system_reset),
        .ready       (ready),
        .failed      (failed),
        .retry_count (retry_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // {dcm_reset, system_reset, ready, failed, retry_count}
    function automatic logic [6:0] mk(input logic dr, input logic sr, input logic rd,
                                      input logic fl, input logic [2:0] rc);
        return {dr, sr, rd, fl, rc};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Expected change n edges after the most recent edge (0 = before the next edge).
    task automatic push_exp(input int dc, input logic [6:0] v);
        q.push_back(exp_t'{cyc: cyc + dc, vec: v});
    endtask

    // Monitor: any change of the output vector must match the head of the queue.
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        exp_t       e;
        prev = 'x;
        #20;
        forever begin
            @(negedge clock or posedge reset);
            #1;
            cur = {dcm_reset, system_reset, ready, failed, retry_count};
            if (cur !== prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got %b at cyc %0d, required no change", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.vec || (e.cyc >= 0 && cyc != e.cyc)) begin
                        n_bad++;
                        $display("FAIL output_change: got %b at cyc %0d, required %b at cyc %0d",
                                 cur, cyc, e.vec, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        dcm_locked = 1'b0;
        q.push_back(exp_t'{cyc: -1, vec: mk(1, 1, 0, 0, 0)});

        // Nominal lock: dcm_reset high 4 cycles, lock 10 cycles later, running after settle.
        tick(3);
        reset = 1'b0;
        push_exp(4, mk(0, 1, 0, 0, 0));
        tick(14);
        dcm_locked = 1'b1;
        push_exp(11, mk(0, 0, 1, 0, 0));

        // Lock loss while running: retry 1, regain after 5 cycles.
        tick(14);
        dcm_locked = 1'b0;
        push_exp(3, mk(1, 1, 0, 0, 1));
        push_exp(7, mk(0, 1, 0, 0, 1));
        tick(5);
        dcm_locked = 1'b1;
        push_exp(11, mk(0, 0, 1, 0, 1));

        // Lock loss into a settle bounce: bounce must not count as a retry.
        tick(14);
        dcm_locked = 1'b0;
        push_exp(3, mk(1, 1, 0, 0, 2));
        push_exp(7, mk(0, 1, 0, 0, 2));
        tick(10);
        dcm_locked = 1'b1;
        tick(4);
        dcm_locked = 1'b0;
        tick(3);
        dcm_locked = 1'b1;
        push_exp(11, mk(0, 0, 1, 0, 2));

        // Async reset while running, then again mid-settle.
        tick(14);
        reset      = 1'b1;
        dcm_locked = 1'b1;
        push_exp(0, mk(1, 1, 0, 0, 0));
        tick(2);
        reset = 1'b0;
        push_exp(4, mk(0, 1, 0, 0, 0));
        tick(8);
        reset = 1'b1;
        push_exp(0, mk(1, 1, 0, 0, 0));

        // Lock arrives on the very cycle the timeout expires: lock wins.
        dcm_locked = 1'b0;
        tick(2);
        reset = 1'b0;
        push_exp(4, mk(0, 1, 0, 0, 0));
        tick(21);
        dcm_locked = 1'b1;
        push_exp(11, mk(0, 0, 1, 0, 0));

        // Repeated timeouts: two retries then failed; later lock is ignored.
        tick(14);
        reset      = 1'b1;
        dcm_locked = 1'b0;
        push_exp(0, mk(1, 1, 0, 0, 0));
        tick(2);
        reset = 1'b0;
        push_exp(4,  mk(0, 1, 0, 0, 0));
        push_exp(24, mk(1, 1, 0, 0, 1));
        push_exp(28, mk(0, 1, 0, 0, 1));
        push_exp(48, mk(1, 1, 0, 0, 2));
        push_exp(52, mk(0, 1, 0, 0, 2));
        push_exp(72, mk(0, 1, 0, 1, 2));
        tick(80);
        dcm_locked = 1'b1;
        tick(30);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_changes: got %0d expected changes never seen, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
